// File: rtl/cache_mem_responder.sv
// Memory-side responder for the set-associative cache: serves line fills after a
// fixed latency and absorbs dirty-line evictions through a small writeback FIFO.
module cache_mem_responder #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int LINE_SIZE_BYTES = 4,
  parameter int MEM_DEPTH       = 1024,
  parameter int READ_LATENCY    = 4,
  parameter int WB_DEPTH        = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_miss,
  input  logic [ADDRESS_WIDTH-1:0]     i_miss_addr,
  output logic [8*LINE_SIZE_BYTES-1:0] o_memory_line,
  output logic                         o_memory_response,
  input  logic                         i_evict,
  input  logic [ADDRESS_WIDTH-1:0]     i_evict_addr,
  input  logic [8*LINE_SIZE_BYTES-1:0] i_evict_data,
  output logic                         o_evict_ready,
  output logic                         o_busy,
  output logic                         o_wb_overflow
);
  localparam int LINE_BITS = 8 * LINE_SIZE_BYTES;
  localparam int LOFF      = $clog2(LINE_SIZE_BYTES);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam int PTR_W     = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W     = $clog2(WB_DEPTH + 1);
  localparam int LAT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  // Eviction handshake: an entry is taken on any edge where i_evict and
  // o_evict_ready are both high; i_evict with o_evict_ready low drops the entry.
  typedef enum logic [1:0] {IDLE, READ_WAIT, RESPOND} state_t;

  state_t               state;
  logic [LAT_W-1:0]     lat_cnt;
  logic [IDX_W-1:0]     miss_idx;
  logic [IDX_W-1:0]     evict_idx;
  logic [IDX_W-1:0]     fifo_idx  [WB_DEPTH];
  logic [LINE_BITS-1:0] fifo_data [WB_DEPTH];
  logic [LINE_BITS-1:0] mem       [MEM_DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr, slot;
  logic [CNT_W-1:0]     count;
  logic [LINE_BITS-1:0] fill_data;
  logic                 push, pop;
  logic                 unused_addr_bits;

  assign evict_idx        = i_evict_addr[LOFF +: IDX_W];
  assign o_evict_ready    = (count < CNT_W'(WB_DEPTH));
  assign o_busy           = (state != IDLE) || (count != '0);
  assign push             = i_evict && o_evict_ready;
  assign pop              = (state == IDLE) && (count != '0);
  assign unused_addr_bits = ^{i_miss_addr, i_evict_addr};

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (int'(p) == WB_DEPTH - 1) return '0;
    return p + 1'b1;
  endfunction

  // Fill source: same-cycle eviction beats youngest queued entry beats the array.
  always_comb begin
    fill_data = mem[miss_idx];
    slot      = rd_ptr;
    for (int i = 0; i < WB_DEPTH; i++) begin
      slot = PTR_W'((int'(rd_ptr) + i) % WB_DEPTH);
      if (i < int'(count) && fifo_idx[slot] == miss_idx) fill_data = fifo_data[slot];
    end
    if (push && evict_idx == miss_idx) fill_data = i_evict_data;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr]  <= evict_idx;
      fifo_data[wr_ptr] <= i_evict_data;
    end
    if (pop) mem[fifo_idx[rd_ptr]] <= fifo_data[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      lat_cnt           <= '0;
      miss_idx          <= '0;
      o_memory_line     <= '0;
      o_memory_response <= 1'b0;
      o_wb_overflow     <= 1'b0;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      count             <= '0;
    end else begin
      o_memory_response <= 1'b0;
      if (i_evict && !o_evict_ready) o_wb_overflow <= 1'b1;
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case (state)
        IDLE: begin
          // Draining writebacks first keeps the array ahead of any new fill.
          if (count == '0 && i_miss) begin
            miss_idx <= i_miss_addr[LOFF +: IDX_W];
            lat_cnt  <= LAT_W'(READ_LATENCY - 1);
            state    <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else begin
            o_memory_line     <= fill_data;
            o_memory_response <= 1'b1;
            state             <= RESPOND;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: a table of evict/miss records with
// hand-computed fill data, followed by hand-written multi-cycle sequences.
module tb_cache_mem_responder;
  localparam int AW  = 32;
  localparam int LB  = 32;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_miss;
  logic [AW-1:0] i_miss_addr;
  logic [LB-1:0] o_memory_line;
  logic          o_memory_response;
  logic          i_evict;
  logic [AW-1:0] i_evict_addr;
  logic [LB-1:0] i_evict_data;
  logic          o_evict_ready;
  logic          o_busy;
  logic          o_wb_overflow;

  int n_cmp = 0;
  int n_err = 0;

  cache_mem_responder #(
    .ADDRESS_WIDTH(AW), .LINE_SIZE_BYTES(4), .MEM_DEPTH(1024),
    .READ_LATENCY(LAT), .WB_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .o_memory_line(o_memory_line), .o_memory_response(o_memory_response),
    .i_evict(i_evict), .i_evict_addr(i_evict_addr), .i_evict_data(i_evict_data),
    .o_evict_ready(o_evict_ready), .o_busy(o_busy), .o_wb_overflow(o_wb_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_evict;
    logic [AW-1:0] addr;
    logic [LB-1:0] data;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock edge and settle, so outputs are sampled and inputs driven off-edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (o_busy && n < 30) begin
      cycle();
      n++;
    end
    if (o_busy) check({name, "_idle_timeout"}, 1, 0);
  endtask

  // Counts edges (continuing from k_in) until the response pulse; drops i_miss then.
  task automatic wait_response(input int k_in, output int k_out);
    k_out = k_in;
    for (int n = 0; n < 30; n++) begin
      cycle();
      k_out++;
      if (o_memory_response) begin
        i_miss = 1'b0;
        return;
      end
    end
    i_miss = 1'b0;
    k_out = -1;
  endtask

  task automatic do_evict(input logic [AW-1:0] a, input logic [LB-1:0] d, input string name);
    check({name, "_ready"}, o_evict_ready, 1);
    i_evict = 1'b1; i_evict_addr = a; i_evict_data = d;
    cycle();
    i_evict = 1'b0;
    check({name, "_busy_after_push"}, o_busy, 1);
    wait_idle(name);
  endtask

  task automatic do_miss(input logic [AW-1:0] a, input logic [LB-1:0] exp, input string name);
    int k;
    i_miss = 1'b1; i_miss_addr = a;
    wait_response(0, k);
    check({name, "_latency"}, k, LAT + 1);
    check({name, "_line"}, o_memory_line, exp);
    cycle();
    check({name, "_pulse_low"}, o_memory_response, 0);
    check({name, "_line_held"}, o_memory_line, exp);
    wait_idle(name);
  endtask

  initial begin
    int  k;
    bit  saw_resp, saw_busy;

    vecs[0]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 32'h0000_0040, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_1040, 32'hA5A5_A5A5};  // aliases line index 0x10
    vecs[3]  = '{1'b0, 32'h0000_0040, 32'hA5A5_A5A5};
    vecs[4]  = '{1'b0, 32'h0000_0043, 32'hA5A5_A5A5};  // byte offset ignored
    vecs[5]  = '{1'b1, 32'h0000_3FFC, 32'h0BAD_F00D};  // top line index 0x3FF
    vecs[6]  = '{1'b0, 32'h0000_0FFC, 32'h0BAD_F00D};
    vecs[7]  = '{1'b1, 32'h0000_0080, 32'h1111_1111};
    vecs[8]  = '{1'b0, 32'h0000_0080, 32'h1111_1111};
    vecs[9]  = '{1'b1, 32'h0000_0200, 32'h55AA_55AA};
    vecs[10] = '{1'b1, 32'h0000_0308, 32'h7777_7777};
    vecs[11] = '{1'b1, 32'h0000_0304, 32'h6666_6666};

    rst = 1'b1; i_miss = 1'b0; i_miss_addr = '0;
    i_evict = 1'b0; i_evict_addr = '0; i_evict_data = '0;
    #1;
    check("rst_line", o_memory_line, 0);
    check("rst_resp", o_memory_response, 0);
    check("rst_ready", o_evict_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_ovf", o_wb_overflow, 0);
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_evict) do_evict(vecs[i].addr, vecs[i].data, $sformatf("vec%0d_evict", i));
      else                  do_miss(vecs[i].addr, vecs[i].data, $sformatf("vec%0d_miss", i));
    end

    // Forwarding: eviction queued mid-read is returned instead of the stale array line.
    i_miss = 1'b1; i_miss_addr = 32'h80;
    cycle(); cycle();
    i_evict = 1'b1; i_evict_addr = 32'h80; i_evict_data = 32'h1234_5678;
    cycle();
    i_evict = 1'b0;
    wait_response(3, k);
    check("fwd_latency", k, LAT + 1);
    check("fwd_line", o_memory_line, 32'h1234_5678);
    cycle();
    check("fwd_busy_drain_pending", o_busy, 1);
    wait_idle("fwd");
    do_miss(32'h80, 32'h1234_5678, "fwd_array_updated");

    // Same-cycle bypass on the last READ_WAIT cycle.
    i_miss = 1'b1; i_miss_addr = 32'h80;
    for (int i = 0; i < LAT; i++) cycle();
    i_evict = 1'b1; i_evict_addr = 32'h80; i_evict_data = 32'hCAFE_F00D;
    cycle();
    i_evict = 1'b0; i_miss = 1'b0;
    check("byp_resp", o_memory_response, 1);
    check("byp_line", o_memory_line, 32'hCAFE_F00D);
    cycle();
    check("byp_pulse_low", o_memory_response, 0);
    wait_idle("byp");
    do_miss(32'h80, 32'hCAFE_F00D, "byp_array_updated");

    // Ordering: queued writebacks drain before the miss is accepted.
    i_evict = 1'b1; i_evict_addr = 32'h00; i_evict_data = 32'h1;
    cycle();
    i_evict_addr = 32'h04; i_evict_data = 32'h2;
    i_miss = 1'b1; i_miss_addr = 32'h04;
    cycle();
    i_evict = 1'b0;
    wait_response(1, k);
    check("ord_latency", k, LAT + 3);
    check("ord_line", o_memory_line, 32'h2);
    cycle();
    wait_idle("ord");
    do_miss(32'h00, 32'h1, "ord_first_entry");

    // Overflow: three evictions during a read, third dropped.
    i_miss = 1'b1; i_miss_addr = 32'h200;
    cycle();
    i_evict = 1'b1; i_evict_addr = 32'h300; i_evict_data = 32'h1;
    cycle();
    check("ovf_ready_one", o_evict_ready, 1);
    i_evict_addr = 32'h304; i_evict_data = 32'h2;
    cycle();
    check("ovf_ready_full", o_evict_ready, 0);
    i_evict_addr = 32'h308; i_evict_data = 32'h3;
    cycle();
    i_evict = 1'b0;
    check("ovf_flag", o_wb_overflow, 1);
    wait_response(4, k);
    check("ovf_latency", k, LAT + 1);
    check("ovf_line", o_memory_line, 32'h55AA_55AA);
    cycle();
    wait_idle("ovf");
    do_miss(32'h304, 32'h2, "ovf_second_kept");
    do_miss(32'h308, 32'h7777_7777, "ovf_third_dropped");
    check("ovf_sticky", o_wb_overflow, 1);

    // Reset during READ_WAIT with a queued eviction.
    i_miss = 1'b1; i_miss_addr = 32'h40;
    cycle();
    i_evict = 1'b1; i_evict_addr = 32'h40; i_evict_data = 32'hBAD0_BAD0;
    cycle();
    i_evict = 1'b0;
    rst = 1'b1;
    #1;
    i_miss = 1'b0;
    check("mid_rst_line", o_memory_line, 0);
    check("mid_rst_resp", o_memory_response, 0);
    check("mid_rst_ready", o_evict_ready, 1);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_ovf", o_wb_overflow, 0);
    cycle(); cycle();
    rst = 1'b0;
    saw_resp = 1'b0; saw_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (o_memory_response) saw_resp = 1'b1;
      if (o_busy) saw_busy = 1'b1;
    end
    check("mid_rst_no_resp", saw_resp, 0);
    check("mid_rst_fifo_empty", saw_busy, 0);
    do_miss(32'h40, 32'hA5A5_A5A5, "post_rst_miss");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
